pipelined_adder_nbit: RTL

Parametrised, pipelined add/subtract unit that succeeds the fixed 8-bit adder. It splits a WIDTH-bit carry chain into STAGES equal slices, one slice per pipeline stage. Operands and results move on valid/ready handshakes, so the unit sits directly in streaming datapaths. It also provides subtract mode and a signed-overflow flag.

---
 rtl/pipelined_adder_nbit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipelined_adder_nbit.sv
// Pipelined add/subtract unit with valid/ready handshakes on both sides.
// The WIDTH-bit carry chain is cut into STAGES equal slices; stage k resolves
// bits [k*S +: S] and hands its carry to stage k+1 on the next clock.
// WIDTH must be an exact multiple of STAGES.
module pipelined_adder_nbit #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int S = WIDTH / STAGES;

    // Index k of each chain is what enters stage k; index k+1 is what stage k
    // holds. Operand chains stop at the last stage, which consumes the final slice.
    logic [STAGES-1:0][WIDTH-1:0] a_ch;
    logic [STAGES-1:0][WIDTH-1:0] b_ch;
    logic [STAGES:0][WIDTH-1:0]   r_ch;
    logic [STAGES:0]              c_ch;
    logic [STAGES:0]              v_ch;
    logic [STAGES:0]              adv;

    // Operand bits below the slice a stage works on are already consumed and
    // are left for synthesis to trim; fold them here so they are not flagged.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{a_ch, b_ch};

    // Entry point: subtract is a + ~b + !cin, so the inversion happens once here
    // and every later stage just adds.
    assign a_ch[0] = a;
    assign b_ch[0] = sub ? ~b : b;
    assign c_ch[0] = sub ? ~cin : cin;
    assign r_ch[0] = '0;
    assign v_ch[0] = in_valid;

    assign in_ready  = adv[0];
    assign out_valid = v_ch[STAGES];
    assign sum       = r_ch[STAGES];
    assign cout      = c_ch[STAGES];

    // Advance chain: a stage may load when it is empty or its successor loads
    // this cycle; the output end advances when the consumer takes the result.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~v_ch[k+1] | adv[k+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [S:0]       slice_w;
            logic [WIDTH-1:0] res_d;
            logic [WIDTH-1:0] res_q;
            logic             carry_d;
            logic             carry_q;
            logic             valid_q;

            // Ripple-add this stage's slice and merge it into the partial result.
            always_comb begin
                slice_w = {1'b0, a_ch[gi][gi*S +: S]}
                        + {1'b0, b_ch[gi][gi*S +: S]}
                        + {{S{1'b0}}, c_ch[gi]};
                res_d               = r_ch[gi];
                res_d[gi*S +: S]    = slice_w[S-1:0];
                carry_d             = slice_w[S];
            end

            // Stage register: valid follows upstream on advance; data only loads
            // with a real beat so a held or bubbled stage keeps its contents.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    res_q   <= '0;
                    carry_q <= 1'b0;
                end else if (adv[gi]) begin
                    valid_q <= v_ch[gi];
                    if (v_ch[gi]) begin
                        res_q   <= res_d;
                        carry_q <= carry_d;
                    end
                end
            end

            assign r_ch[gi+1] = res_q;
            assign c_ch[gi+1] = carry_q;
            assign v_ch[gi+1] = valid_q;

            if (gi < STAGES - 1) begin : g_fwd
                logic [WIDTH-1:0] a_q;
                logic [WIDTH-1:0] b_q;

                // Carry the not-yet-added operand bits along with the beat.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (adv[gi] && v_ch[gi]) begin
                        a_q <= a_ch[gi];
                        b_q <= b_ch[gi];
                    end
                end

                assign a_ch[gi+1] = a_q;
                assign b_ch[gi+1] = b_q;
            end else begin : g_last
                logic ovf_d;
                logic ovf_q;

                // Carry into the MSB is a^b^sum at that bit; overflow is that
                // carry disagreeing with the carry out.
                assign ovf_d = a_ch[gi][WIDTH-1] ^ b_ch[gi][WIDTH-1]
                             ^ res_d[WIDTH-1] ^ carry_d;

                // Overflow flag registered alongside the final slice.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        ovf_q <= 1'b0;
                    end else if (adv[gi] && v_ch[gi]) begin
                        ovf_q <= ovf_d;
                    end
                end

                assign ovf = ovf_q;
            end
        end
    endgenerate

endmodule
